// File: rtl/xram_bus_master.sv
// Command-driven byte bus master: turns a (wr, addr, len) command into len+1
// single-beat bus transfers, one handshaked response per beat.
module xram_bus_master #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    input  logic [3:0]  cmd_len,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic [1:0]  rsp_err,
    output logic        rsp_last,
    output logic        stb,
    output logic        wr,
    output logic [15:0] addr,
    output logic [7:0]  data_out,
    input  logic [7:0]  data_in,
    input  logic        ack,
    input  logic        in_addr_range,
    output logic        busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_DEC = 2'b01;
    localparam logic [1:0] ERR_TMO = 2'b10;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state;
    logic       alive;    // holds cmd_ready low until the first edge after reset
    logic [3:0] remain;
    logic [7:0] tmo_cnt;

    assign cmd_ready = alive && (state == S_IDLE);
    assign stb       = (state == S_REQ);
    assign rsp_valid = (state == S_RESP);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            alive    <= 1'b0;
            wr       <= 1'b0;
            addr     <= 16'h0000;
            data_out <= 8'h00;
            remain   <= 4'd0;
            tmo_cnt  <= 8'd0;
            rsp_data <= 8'h00;
            rsp_err  <= ERR_OK;
            rsp_last <= 1'b0;
        end else begin
            alive <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        wr       <= cmd_wr;
                        addr     <= cmd_addr;
                        data_out <= cmd_wdata;
                        remain   <= cmd_len;
                        tmo_cnt  <= 8'd0;
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    // ack beats decode error beats timeout; range is only
                    // looked at on the first cycle of the beat
                    if (ack) begin
                        rsp_err  <= ERR_OK;
                        rsp_data <= wr ? 8'h00 : data_in;
                        rsp_last <= (remain == 4'd0);
                        state    <= S_RESP;
                    end else if (tmo_cnt == 8'd0 && !in_addr_range) begin
                        rsp_err  <= ERR_DEC;
                        rsp_data <= 8'h00;
                        rsp_last <= 1'b1;
                        state    <= S_RESP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        rsp_err  <= ERR_TMO;
                        rsp_data <= 8'h00;
                        rsp_last <= 1'b1;
                        state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    // errors force rsp_last, so !rsp_last means "more beats, no error"
                    if (rsp_ready) begin
                        if (!rsp_last) begin
                            addr    <= addr + 16'd1;
                            remain  <= remain - 4'd1;
                            tmo_cnt <= 8'd0;
                            state   <= S_REQ;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xram_bus_master.sv
// Randomized bench for xram_bus_master: a behavioural bus target plus a
// per-beat model of expected strobe length, error code and response data.
module tb_xram_bus_master;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_wr = 1'b0;
    logic [15:0] cmd_addr = 16'h0;
    logic [7:0]  cmd_wdata = 8'h0;
    logic [3:0]  cmd_len = 4'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_err;
    logic        rsp_last;
    logic        stb;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data_out;
    logic [7:0]  data_in;
    logic        ack;
    logic        in_addr_range;
    logic        busy;

    int ncmp = 0;
    int nfail = 0;

    xram_bus_master #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_last(rsp_last),
        .stb(stb), .wr(wr), .addr(addr), .data_out(data_out),
        .data_in(data_in), .ack(ack), .in_addr_range(in_addr_range), .busy(busy)
    );

    always #5 clk = ~clk;

    // Target: acks on the planned strobe cycle, drives random ack noise while idle.
    int         plan_ack = 0;
    logic       plan_rng0 = 1'b1;
    logic       plan_rng1 = 1'b1;
    logic       noise = 1'b0;
    logic       ovr_en = 1'b0;
    logic [7:0] ovr_val = 8'h00;
    logic [7:0] stb_cnt;

    function automatic logic [7:0] tgt_byte(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) stb_cnt <= 8'd0;
        else if (stb) stb_cnt <= stb_cnt + 8'd1;
        else stb_cnt <= 8'd0;
    end

    assign ack           = stb ? ((int'(stb_cnt) + 1) == plan_ack) : noise;
    assign in_addr_range = (stb_cnt == 8'd0) ? plan_rng0 : plan_rng1;
    assign data_in       = ovr_en ? ovr_val : tgt_byte(addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: ack on cycle ackc; 1: decode error; 2: timeout
    task automatic set_plan(input int mode, input int ackc);
        case (mode)
            0: begin
                plan_ack  = ackc;
                plan_rng0 = (ackc == 1) ? 1'($urandom) : 1'b1;
                plan_rng1 = 1'($urandom);
            end
            1: begin
                plan_ack  = 2 + int'($urandom % 3);
                plan_rng0 = 1'b0;
                plan_rng1 = 1'($urandom);
            end
            default: begin
                plan_ack  = 0;
                plan_rng0 = 1'b1;
                plan_rng1 = 1'($urandom);
            end
        endcase
    endtask

    task automatic pick(input int fmode, input int fack, output int mode, output int ackc);
        int r;
        if (fmode >= 0) begin
            mode = fmode;
            ackc = fack;
        end else begin
            r = int'($urandom % 8);
            mode = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            ackc = 1 + int'($urandom % TMO);
        end
    endtask

    task automatic run_cmd(input logic w, input logic [15:0] a, input logic [7:0] wd,
                           input logic [3:0] len, input int fmode, input int fack, input int bp);
        int mode, ackc, n, nexp, hold;
        logic [15:0] ea;
        logic [1:0]  eerr;
        logic        elast;
        logic [7:0]  edata;
        pick(fmode, fack, mode, ackc);
        set_plan(mode, ackc);
        cmd_wr = w; cmd_addr = a; cmd_wdata = wd; cmd_len = len; cmd_valid = 1'b1;
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_wr = 1'($urandom); cmd_addr = 16'($urandom); cmd_wdata = 8'($urandom); cmd_len = 4'($urandom);
        for (int i = 0; i <= int'(len); i++) begin
            ea    = a + 16'(i);
            nexp  = (mode == 0) ? ackc : (mode == 1) ? 1 : TMO;
            eerr  = 2'(mode);
            elast = (i == int'(len)) || (mode != 0);
            edata = (mode != 0 || w) ? 8'h00 : (ovr_en ? ovr_val : tgt_byte(ea));
            n = 0;
            while (stb === 1'b1 && n < 20) begin
                chk("beat_bus", {7'd0, wr, ea, data_out}, {7'd0, w, ea, wd});
                n++;
                noise = 1'($urandom);
                @(negedge clk);
            end
            chk("stb_cycles", 32'(n), 32'(nexp));
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_err_last", {29'd0, rsp_err, rsp_last}, {29'd0, eerr, elast});
            if (mode == 0) chk("rsp_data", 32'(rsp_data), 32'(edata));
            hold = (bp < 0) ? int'($urandom % 3) : bp;
            repeat (hold) begin
                @(negedge clk);
                chk("rsp_hold", {20'd0, stb, rsp_valid, rsp_err, rsp_last, (mode == 0) ? rsp_data : 8'h00},
                                {20'd0, 1'b0, 1'b1, eerr, elast, (mode == 0) ? edata : 8'h00});
            end
            pick(fmode, fack, mode, ackc);
            set_plan(mode, ackc);
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            if (elast) break;
        end
        chk("back_idle", {29'd0, busy, cmd_ready, stb}, 32'b010);
    endtask

    initial begin
        rst = 1'b0;
        #12;
        chk("reset_state", {7'd0, stb, wr, busy, cmd_ready, rsp_valid, rsp_err, rsp_last},
                           32'd0);
        chk("reset_bus", {8'd0, addr, data_out}, 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {30'd0, cmd_ready, busy}, 32'b10);

        // single read, ack on 3rd strobe cycle with 0xA5
        ovr_en = 1'b1; ovr_val = 8'hA5;
        run_cmd(1'b0, 16'h1234, 8'h00, 4'd0, 0, 3, 0);
        ovr_en = 1'b0;
        // write fill across the address wrap
        run_cmd(1'b1, 16'hFFFE, 8'h5C, 4'd3, 0, 1, 0);
        // decode error aborts a 3-beat read
        run_cmd(1'b0, 16'h0100, 8'h00, 4'd2, 1, 0, 0);
        // timeout, then ack on the timeout edge
        run_cmd(1'b0, 16'h2000, 8'h00, 4'd0, 2, 0, 0);
        run_cmd(1'b0, 16'h2001, 8'h00, 4'd1, 0, TMO, 0);
        // backpressure
        run_cmd(1'b0, 16'h3000, 8'h11, 4'd1, 0, 2, 5);

        for (int k = 0; k < 40; k++)
            run_cmd(1'($urandom), (k % 4 == 0) ? 16'hFFF8 + 16'($urandom % 8) : 16'($urandom),
                    8'($urandom), 4'($urandom), -1, 0, -1);

        // reset while a write beat is in flight
        set_plan(0, TMO);
        cmd_wr = 1'b1; cmd_addr = 16'hBEEF; cmd_wdata = 8'h77; cmd_len = 4'd5; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_stb", {30'd0, stb, busy}, 32'b11);
        rst = 1'b0;
        #1;
        chk("async_reset_ctrl", {28'd0, stb, busy, rsp_valid, cmd_ready}, 32'd0);
        chk("async_reset_bus", {7'd0, wr, addr, data_out}, 32'd0);
        chk("async_reset_rsp", {21'd0, rsp_data, rsp_err, rsp_last}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_release", {29'd0, cmd_ready, busy, stb}, 32'b100);
        run_cmd(1'b0, 16'h0042, 8'h00, 4'd1, 0, 2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/xram_bus_master.md
XRAM_BUS_MASTER -- requirements
Module: xram_bus_master

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum stb-high cycles without ack before a beat aborts (legal range 1..255).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low; it is the only reset.
REQ-004 cmd_valid  input  1  command offered; cmd_ready  output  1  command accepted when both are high at a clock edge.
REQ-005 cmd_wr  input  1  1=write, 0=read; cmd_addr  input  16  start address; cmd_wdata  input  8  write byte; cmd_len  input  4  beats minus one (1..16 beats).
REQ-006 rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-007 rsp_data  output  8  read byte, 0x00 for writes; rsp_err  output  2  00 ok, 01 decode error, 10 timeout; rsp_last  output  1  final response of the command.
REQ-008 stb  output  1; wr  output  1; addr  output  16; data_out  output  8  bus request toward the target's data_in.
REQ-009 data_in  input  8; ack  input  1; in_addr_range  input  1  target response signals.
REQ-010 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-011 The FSM SHALL have states IDLE, REQ, RESP.
REQ-012 cmd_ready SHALL be high only in IDLE; the accepting edge SHALL latch cmd_wr, cmd_addr, cmd_wdata, cmd_len and move to REQ.
REQ-013 In REQ: stb=1; wr, addr, data_out held stable. The latched write byte SHALL be repeated on every write beat (fill).
REQ-014 Each beat's timeout counter SHALL clear on entry to REQ and increment once per REQ cycle.
REQ-015 At an edge in REQ, priority (highest first): ack=1 -> rsp_err=00, rsp_data=data_in (reads) or 0x00 (writes); else in_addr_range=0 on the beat's first REQ cycle -> rsp_err=01; else counter reaches TIMEOUT -> rsp_err=10; else stay in REQ.
REQ-016 in_addr_range SHALL be ignored after the first REQ cycle of a beat.
REQ-017 On any REQ exit, stb SHALL be low the next cycle and the FSM SHALL enter RESP with rsp_valid=1.
REQ-018 rsp_data, rsp_err, rsp_last SHALL remain stable while rsp_valid=1 and rsp_ready=0.
REQ-019 rsp_last SHALL be 1 on the final beat and on any error response.
REQ-020 On the RESP handshake edge: if the beat was not last and not in error, addr SHALL increment by 1 (0xFFFF wraps to 0x0000), the remaining-beat count SHALL decrement, and the FSM SHALL return to REQ; otherwise it SHALL return to IDLE.
REQ-021 An error SHALL abort the remaining beats of the command.
REQ-022 stb SHALL be low for at least one cycle between consecutive beats; ack while stb=0 SHALL be ignored.
REQ-023 Minimum per-beat latency: stb rises the cycle after acceptance or the RESP handshake; rsp_valid rises the cycle after the ack edge.

Reset
REQ-024 While rst=0, and asynchronously on its assertion (including mid-transfer), the block SHALL enter IDLE with outputs:
- stb=0, wr=0, addr=0x0000, data_out=0x00
- rsp_valid=0, rsp_data=0x00, rsp_err=00, rsp_last=0
- busy=0, cmd_ready=0
REQ-025 On the first clock edge after rst deasserts, cmd_ready SHALL be 1; no partial beat, command or response SHALL survive reset.

Verification
REQ-026 Single read: addr=0x1234, len=0; ack=1 with data_in=0xA5 on the 3rd stb cycle -> stb high 3 cycles, wr=0; then rsp_data=0xA5, rsp_err=00, rsp_last=1.
REQ-027 Write fill burst: addr=0xFFFE, wdata=0x5C, len=3, rsp_ready=1, ack=1 after 1 cycle -> four stb pulses to addr 0xFFFE, 0xFFFF, 0x0000, 0x0001, data_out=0x5C; rsp_last only on the 4th response.
REQ-028 Decode error: in_addr_range=0, ack=0 on the first beat of a len=2 read -> stb high 1 cycle; one response, rsp_err=01, rsp_last=1; then IDLE.
REQ-029 Timeout with TIMEOUT=4 and ack=0 -> stb high exactly 4 cycles; rsp_err=10, rsp_last=1. Ack on the same edge as the timeout -> rsp_err=00.
REQ-030 Backpressure and reset: rsp_ready=0 for 5 cycles -> rsp_* stable and stb=0. Assert rst mid-REQ -> stb, busy and rsp_valid drop at once; after release, cmd_ready=1.
